// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI word receiver: mode encoding and width helpers.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Modes 1 and 2 (cpol != cpha) sample on the SCLK falling edge.
    function automatic logic sample_on_neg(input spi_mode_e mode);
        return (mode == SPI_MODE1) || (mode == SPI_MODE2);
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Word FIFO with a registered head word and extra-bit wrap pointers.
module spi_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    ready_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    output logic                    overflow_o,
    output logic [clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [WIDTH-1:0] head_q, head_nx;
    logic             overflow_q;
    logic             empty, full, pop, push_ok;

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        pop       = !empty && ready_i;
        push_ok   = push_i && (!full || pop);
        wr_ptr_nx = wr_ptr + PW'(push_ok);
        rd_ptr_nx = rd_ptr + PW'(pop);
        // Head is precomputed so a word pushed into the head slot shows up next cycle.
        if (wr_ptr_nx == rd_ptr_nx) begin
            head_nx = '0;
        end else if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_nx[AW-1:0])) begin
            head_nx = wdata_i;
        end else begin
            head_nx = mem[rd_ptr_nx[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem[wr_ptr[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            head_q <= head_nx;
            if (push_i && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign data_o     = head_q;
    assign valid_o    = !empty;
    assign overflow_o = overflow_q;
    assign level_o    = wr_ptr - rd_ptr;

endmodule

// File: rtl/spi_word_receiver.sv
// SPI receive shifter assembling WIDTH-bit words into an output FIFO.
module spi_word_receiver
    import spi_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    en_i,
    input  logic                    miso_i,
    input  logic                    scl_pos_edge_i,
    input  logic                    scl_neg_edge_i,
    input  logic                    cpol_i,
    input  logic                    cpha_i,
    input  logic                    lsb_first_i,
    input  logic                    clear_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    overflow_o,
    output logic [clog2(DEPTH):0]   level_o
);
    localparam int unsigned CW = clog2(WIDTH);

    spi_mode_e        mode;
    logic [CW-1:0]    bit_cnt, bit_idx;
    logic [WIDTH-1:0] shift_q, word_base, shift_nx;
    logic             sample, last_bit, push;

    always_comb begin
        mode      = spi_mode_e'({cpol_i, cpha_i});
        sample    = en_i && (sample_on_neg(mode) ? scl_neg_edge_i : scl_pos_edge_i);
        bit_idx   = lsb_first_i ? bit_cnt : (CW'(WIDTH - 1) - bit_cnt);
        last_bit  = (bit_cnt == CW'(WIDTH - 1));
        // First bit of a word starts from a clean register.
        word_base = (bit_cnt == '0) ? '0 : shift_q;
        shift_nx  = word_base | (WIDTH'(miso_i) << bit_idx);
        push      = sample && last_bit;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (!en_i) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (sample) begin
            if (last_bit) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shift_q <= shift_nx;
            end
        end
    end

    assign busy_o = (bit_cnt != '0);

    spi_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .clear_i    (clear_i),
        .push_i     (push),
        .wdata_i    (shift_nx),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o),
        .level_o    (level_o)
    );

endmodule

// File: tb/tb_spi_word_receiver.sv
// Directed bench for spi_word_receiver (WIDTH 8, DEPTH 4).
module tb_spi_word_receiver;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       en_i = 1'b0;
    logic       miso_i = 1'b0;
    logic       scl_pos_edge_i = 1'b0;
    logic       scl_neg_edge_i = 1'b0;
    logic       cpol_i = 1'b0;
    logic       cpha_i = 1'b0;
    logic       lsb_first_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic       busy_o;
    logic       overflow_o;
    logic [2:0] level_o;

    int checks = 0;
    int errors = 0;
    logic sample_neg = 1'b0;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       lsb;
        logic [7:0] serial;
        logic [7:0] expected;
    } vec_t;

    vec_t vecs[6];

    spi_word_receiver #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .en_i           (en_i),
        .miso_i         (miso_i),
        .scl_pos_edge_i (scl_pos_edge_i),
        .scl_neg_edge_i (scl_neg_edge_i),
        .cpol_i         (cpol_i),
        .cpha_i         (cpha_i),
        .lsb_first_i    (lsb_first_i),
        .clear_i        (clear_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .level_o        (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One sample strobe carrying b, then a cycle of the ignored strobe carrying ~b.
    task automatic strobe_bit(input logic b, input logic rdy);
        miso_i  = b;
        ready_i = rdy;
        if (sample_neg) scl_neg_edge_i = 1'b1; else scl_pos_edge_i = 1'b1;
        @(negedge clk_i);
        scl_pos_edge_i = 1'b0;
        scl_neg_edge_i = 1'b0;
        ready_i = 1'b0;
        miso_i  = ~b;
        if (sample_neg) scl_pos_edge_i = 1'b1; else scl_neg_edge_i = 1'b1;
        @(negedge clk_i);
        scl_pos_edge_i = 1'b0;
        scl_neg_edge_i = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] serial, input int n);
        for (int i = 0; i < n; i++) begin
            strobe_bit(serial[7-i], 1'b0);
        end
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
        cpol_i      = cpol;
        cpha_i      = cpha;
        lsb_first_i = lsb;
        sample_neg  = cpol ^ cpha;
    endtask

    task automatic drain(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] exp_w [4];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_valid%0d", k), 32'(valid_o), 32'd1);
            check($sformatf("drain_data%0d", k), 32'(data_o), 32'(exp_w[k]));
            @(negedge clk_i);
        end
        ready_i = 1'b0;
        check("drain_empty_valid", 32'(valid_o), 32'd0);
        check("drain_empty_level", 32'(level_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h01};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'hCA, 8'h53};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h0F, 8'hF0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h80};

        repeat (2) @(negedge clk_i);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        reset_ni = 1'b1;
        @(negedge clk_i);
        en_i = 1'b1;

        for (int v = 0; v < 6; v++) begin
            set_mode(vecs[v].cpol, vecs[v].cpha, vecs[v].lsb);
            send_bits(vecs[v].serial, 4);
            check($sformatf("vec%0d_busy", v), 32'(busy_o), 32'd1);
            for (int i = 4; i < 7; i++) strobe_bit(vecs[v].serial[7-i], 1'b0);
            // Last bit sampled at the posedge just passed: word must already be visible.
            miso_i = vecs[v].serial[0];
            if (sample_neg) scl_neg_edge_i = 1'b1; else scl_pos_edge_i = 1'b1;
            @(negedge clk_i);
            scl_pos_edge_i = 1'b0;
            scl_neg_edge_i = 1'b0;
            check($sformatf("vec%0d_valid", v), 32'(valid_o), 32'd1);
            check($sformatf("vec%0d_data", v), 32'(data_o), 32'(vecs[v].expected));
            check($sformatf("vec%0d_busy_done", v), 32'(busy_o), 32'd0);
            ready_i = 1'b1;
            @(negedge clk_i);
            ready_i = 1'b0;
            check($sformatf("vec%0d_popped", v), 32'(valid_o), 32'd0);
        end

        // Overflow: five words into a four-deep FIFO with no consumer.
        set_mode(1'b0, 1'b0, 1'b0);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
        send_bits(8'h44, 8);
        send_bits(8'h55, 8);
        check("ovf_level", 32'(level_o), 32'd4);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        drain(8'h11, 8'h22, 8'h33, 8'h44);
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        send_bits(8'h66, 8);
        send_bits(8'h77, 8);
        check("pre_clear_level", 32'(level_o), 32'd2);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clear_level", 32'(level_o), 32'd0);
        check("clear_valid", 32'(valid_o), 32'd0);
        check("clear_overflow", 32'(overflow_o), 32'd0);

        // Full FIFO, last bit of word 5 sampled together with a pop.
        send_bits(8'h01, 8);
        send_bits(8'h02, 8);
        send_bits(8'h03, 8);
        send_bits(8'h04, 8);
        send_bits(8'h05, 7);
        strobe_bit(1'b1, 1'b1);
        check("fullpop_overflow", 32'(overflow_o), 32'd0);
        check("fullpop_level", 32'(level_o), 32'd4);
        drain(8'h02, 8'h03, 8'h04, 8'h05);

        // en_i drop mid-word; stored word stays readable.
        send_bits(8'h66, 8);
        send_bits(8'hFF, 3);
        check("en_busy_before", 32'(busy_o), 32'd1);
        en_i = 1'b0;
        @(negedge clk_i);
        check("en_low_busy", 32'(busy_o), 32'd0);
        strobe_bit(1'b1, 1'b0);
        check("en_low_busy2", 32'(busy_o), 32'd0);
        check("en_low_level", 32'(level_o), 32'd1);
        check("en_low_data", 32'(data_o), 32'h66);
        en_i = 1'b1;
        send_bits(8'h3C, 8);
        check("en_level", 32'(level_o), 32'd2);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("en_data", 32'(data_o), 32'h3C);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;

        // Asynchronous reset mid-word with two words stored.
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        send_bits(8'hE0, 3);
        #2 reset_ni = 1'b0;
        #1;
        check("arst_data", 32'(data_o), 32'd0);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_overflow", 32'(overflow_o), 32'd0);
        check("arst_level", 32'(level_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        send_bits(8'h9A, 8);
        check("post_rst_level", 32'(level_o), 32'd1);
        check("post_rst_data", 32'(data_o), 32'h9A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_word_receiver.md
SPI_WORD_RECEIVER -- requirements
Module: spi_word_receiver

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set received word width in bits; legal range 4..32.
REQ-002 Parameter DEPTH, default 4, SHALL set output FIFO depth in words; power of two, 2..16.
REQ-003 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 en_i  input  1  receive enable; low aborts any partial word.
REQ-006 miso_i  input  1  serial data, already synchronised to clk_i.
REQ-007 scl_pos_edge_i  input  1  one-cycle strobe marking an SCLK rising edge.
REQ-008 scl_neg_edge_i  input  1  one-cycle strobe marking an SCLK falling edge.
REQ-009 cpol_i, cpha_i  input  1 each  SPI mode select; stable while en_i high.
REQ-010 lsb_first_i  input  1  bit order, 0 = MSB first; stable while en_i high.
REQ-011 clear_i  input  1  synchronous flush of FIFO and overflow flag.
REQ-012 data_o  output  WIDTH  FIFO head word.
REQ-013 valid_o  output  1  data_o holds a valid word.
REQ-014 ready_i  input  1  consumer accepts data_o when valid_o and ready_i are both high.
REQ-015 busy_o  output  1  partial word in progress (bit count nonzero).
REQ-016 overflow_o  output  1  sticky, a completed word was dropped.
REQ-017 level_o  output  clog2(DEPTH)+1  words currently stored.

Function
REQ-018 Sample strobe SHALL be scl_pos_edge_i when cpol_i XOR cpha_i = 0, else scl_neg_edge_i; the other strobe is ignored.
REQ-019 On each sample strobe with en_i high, miso_i SHALL be stored at bit index (WIDTH-1-n) when lsb_first_i = 0, or index n when lsb_first_i = 1, where n is the bit count 0..WIDTH-1.
REQ-020 Bit count SHALL increment per sample and wrap to 0 on the WIDTH-th sample, with no idle sample between words.
REQ-021 Completed word SHALL be written to the FIFO on the same clock edge as its last sample, giving valid_o high and data_o equal to the word on the next cycle when the FIFO was empty.
REQ-022 Shift register bits not yet sampled SHALL read 0; first sample of a word SHALL clear stale bits.
REQ-023 Pop SHALL occur on every cycle with valid_o and ready_i high; data_o SHALL advance to the next word on the following cycle.
REQ-024 Push on full FIFO without a same-cycle pop SHALL drop the new word, keep contents unchanged and set overflow_o.
REQ-025 Push on full FIFO with a same-cycle pop SHALL complete both; level_o unchanged; overflow_o not set.
REQ-026 Simultaneous push and pop at any level SHALL leave level_o unchanged.
REQ-027 en_i low SHALL clear bit count and shift register within one cycle; FIFO contents SHALL be retained and readable.
REQ-028 clear_i SHALL empty the FIFO and clear overflow_o next cycle, and SHALL take priority over a same-cycle push or pop; the partial word is unaffected.
REQ-029 overflow_o SHALL remain set until clear_i or reset.

Reset
REQ-030 reset_ni low SHALL asynchronously force bit count 0, shift register 0, FIFO empty, data_o 0, valid_o 0, busy_o 0, overflow_o 0 and level_o 0.
REQ-031 Reset mid-word SHALL discard the partial word; the first sample strobe after release SHALL be bit n = 0.

Structure
REQ-032 Package spi_rx_pkg SHALL hold SPI mode encoding constants and the clog2 helper used for counter and pointer widths.
REQ-033 FIFO SHALL be one sub-module spi_rx_fifo (WIDTH, DEPTH), with registered read head and wrap-around read and write pointers carrying one extra bit for full/empty.

Verification
REQ-034 Mode 0, MSB first, WIDTH 8: shift 0xA5 on pos strobes -> data_o = 0xA5 and valid_o high one cycle after the 8th strobe.
REQ-035 Mode 3, LSB first: shift bits 1,0,0,0,0,0,0,0 on pos strobes -> data_o = 0x01; neg strobes have no effect.
REQ-036 Run ready_i low and shift 5 words into DEPTH 4 -> level_o = 4, overflow_o = 1, popped words are words 1-4; clear_i -> level_o = 0, overflow_o = 0.
REQ-037 FIFO full, 8th bit of word 5 sampled in the same cycle as a pop -> no overflow, level_o stays 4, word 5 read out last.
REQ-038 Drop en_i after 3 bits, raise it again, shift 0x3C -> data_o = 0x3C; busy_o low while en_i is low.
REQ-039 Assert reset_ni low asynchronously mid-word with 2 words stored -> all outputs 0 immediately; the next full word is received correctly.
